// File: rtl/fb_pipe_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fb_pipe_flush_ctrl
// Description : Stall/flush sequencer for the 5-stage Firebird pipeline with
//               post-redirect mispredict shadow and saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_pipe_flush_ctrl #(
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mispredict,
    input  logic [31:0]      redirect_pc,
    input  logic             load_use_hazard,
    input  logic             dmem_busy,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    localparam logic [1:0]       c_shadow_init = 2'(SHADOW_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    state_t           r_state;
    logic [1:0]       r_shadow_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_accept;
    logic w_bubble;

    // Busy freezes everything, so a mispredict held across busy is taken once it drops.
    assign w_accept = !dmem_busy && mispredict && (r_state == ST_RUN);
    assign w_bubble = !dmem_busy && !w_accept && load_use_hazard;

    assign mispredict_cnt = r_mispredict_cnt;
    assign bubble_cnt     = r_bubble_cnt;

    always_comb begin
        pc_we          = 1'b1;
        ifid_we        = 1'b1;
        idex_we        = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc_o  = redirect_pc;
        if (rst) begin
            pc_we         = 1'b0;
            ifid_we       = 1'b0;
            idex_we       = 1'b0;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            redirect_pc_o = 32'd0;
        end else if (dmem_busy) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_we = 1'b0;
        end else if (w_accept) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            exmem_flush    = 1'b1;
            redirect_valid = 1'b1;
        end else if (load_use_hazard) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_RUN;
            r_shadow_cnt     <= 2'd0;
            r_mispredict_cnt <= '0;
            r_bubble_cnt     <= '0;
        end else if (!dmem_busy) begin
            if (w_accept) begin
                if (r_mispredict_cnt != c_cnt_max) begin
                    r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
                end
                if (c_shadow_init != 2'd0) begin
                    r_state      <= ST_SHADOW;
                    r_shadow_cnt <= c_shadow_init;
                end
            end else if (r_state == ST_SHADOW) begin
                if (r_shadow_cnt <= 2'd1) begin
                    r_state      <= ST_RUN;
                    r_shadow_cnt <= 2'd0;
                end else begin
                    r_shadow_cnt <= r_shadow_cnt - 2'd1;
                end
            end
            if (w_bubble && (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_pipe_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_pipe_flush_ctrl
// Description : Self-checking bench for fb_pipe_flush_ctrl (scoreboard queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_pipe_flush_ctrl;

    localparam int CNT_W = 4;
    localparam int SHAD  = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic             load_use_hazard;
    logic             dmem_busy;
    logic             pc_we, ifid_we, idex_we;
    logic             ifid_flush, idex_flush, exmem_flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc_o;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    always #5 clk = ~clk;

    fb_pipe_flush_ctrl #(
        .SHADOW_CYCLES (SHAD),
        .CNT_W         (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .load_use_hazard (load_use_hazard),
        .dmem_busy       (dmem_busy),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .idex_we         (idex_we),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc_o   (redirect_pc_o),
        .mispredict_cnt  (mispredict_cnt),
        .bubble_cnt      (bubble_cnt)
    );

    typedef struct packed {
        logic [2:0]  we;
        logic [2:0]  fl;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] mc;
        logic [31:0] bc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_shadow = 0;
    int   m_mc = 0;
    int   m_bc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: drive, predict, compare mid-cycle, then advance the model.
    task automatic step(input logic r, input logic m, input logic [31:0] pc,
                        input logic lu, input logic b);
        exp_t e;
        exp_t got;
        bit   acc;
        rst = r; mispredict = m; redirect_pc = pc; load_use_hazard = lu; dmem_busy = b;
        acc = !r && !b && m && (m_shadow == 0);
        e.mc = 32'(m_mc);
        e.bc = 32'(m_bc);
        e.rv = 1'b0;
        e.rpc = pc;
        if (r) begin
            e.we = 3'b000; e.fl = 3'b111; e.rpc = 32'd0;
        end else if (b) begin
            e.we = 3'b000; e.fl = 3'b000;
        end else if (acc) begin
            e.we = 3'b111; e.fl = 3'b111; e.rv = 1'b1;
        end else if (lu) begin
            e.we = 3'b001; e.fl = 3'b010;
        end else begin
            e.we = 3'b111; e.fl = 3'b000;
        end
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        chk("we",        {29'd0, pc_we, ifid_we, idex_we}, {29'd0, got.we});
        chk("flush",     {29'd0, ifid_flush, idex_flush, exmem_flush}, {29'd0, got.fl});
        chk("redir_vld", {31'd0, redirect_valid}, {31'd0, got.rv});
        chk("redir_pc",  redirect_pc_o, got.rpc);
        chk("mp_cnt",    32'(mispredict_cnt), got.mc);
        chk("bub_cnt",   32'(bubble_cnt), got.bc);
        @(posedge clk);
        if (r) begin
            m_shadow = 0; m_mc = 0; m_bc = 0;
        end else if (!b) begin
            if (acc) begin
                if (m_mc < CMAX) m_mc++;
                m_shadow = SHAD;
            end else if (m_shadow > 0) begin
                m_shadow--;
            end
            if (!acc && lu && m_bc < CMAX) m_bc++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; mispredict = 1'b0; redirect_pc = 32'd0;
        load_use_hazard = 1'b0; dmem_busy = 1'b0;
        @(posedge clk); #1;

        // reset held two cycles, then normal flow
        step(1, 0, 32'h10, 0, 0);
        step(1, 1, 32'h20, 1, 1);
        chk("rst_mp_cnt", 32'(mispredict_cnt), 32'd0);
        step(0, 0, 32'h11, 0, 0);
        step(0, 0, 32'h12, 0, 0);

        // mispredict accepted, two shadowed, third accepted
        step(0, 1, 32'h40, 0, 0);
        chk("mp_first", 32'(mispredict_cnt), 32'd1);
        step(0, 1, 32'h41, 0, 0);
        step(0, 1, 32'h42, 0, 0);
        step(0, 1, 32'h80, 0, 0);
        chk("mp_third", 32'(mispredict_cnt), 32'd2);
        step(0, 0, 32'h81, 0, 0);
        step(0, 0, 32'h82, 0, 0);

        // single load-use bubble
        step(0, 0, 32'h83, 1, 0);
        chk("bubble_one", 32'(bubble_cnt), 32'd1);
        step(0, 0, 32'h84, 0, 0);

        // freeze with a held mispredict, taken once busy drops
        step(0, 1, 32'h90, 0, 1);
        step(0, 1, 32'h90, 1, 1);
        step(0, 1, 32'h90, 0, 1);
        chk("frozen_mp", 32'(mispredict_cnt), 32'd2);
        step(0, 1, 32'h90, 0, 0);
        chk("post_busy_mp", 32'(mispredict_cnt), 32'd3);
        step(0, 0, 32'h91, 0, 1);
        step(0, 0, 32'h92, 0, 0);
        step(0, 0, 32'h93, 0, 0);

        // mispredict + load-use together, then load-use inside the shadow
        step(0, 1, 32'hA0, 1, 0);
        chk("mp_lu_bub", 32'(bubble_cnt), 32'd1);
        step(0, 1, 32'hA1, 1, 0);
        step(0, 0, 32'hA2, 1, 0);
        step(0, 0, 32'hA3, 0, 0);

        // bubble counter saturation
        for (int i = 0; i < CMAX + 2; i++) step(0, 0, 32'hB0 + 32'(i), 1, 0);
        chk("bub_sat", 32'(bubble_cnt), 32'(CMAX));
        step(0, 0, 32'hC0, 0, 0);

        // reset mid-shadow, mispredict accepted right after release
        step(0, 1, 32'hD0, 0, 0);
        step(1, 1, 32'hD1, 0, 0);
        step(0, 1, 32'hD2, 0, 0);
        chk("mp_after_rst", 32'(mispredict_cnt), 32'd1);

        // reset mid-freeze
        step(0, 0, 32'hE0, 0, 0);
        step(0, 0, 32'hE1, 0, 0);
        step(0, 1, 32'hE2, 0, 1);
        step(1, 1, 32'hE2, 0, 1);
        step(0, 1, 32'hE3, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0), $urandom(),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        // mispredict counter saturation
        step(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3 * (CMAX + 2); i++) step(0, 1, 32'hF00 + 32'(i), 0, 0);
        chk("mp_sat", 32'(mispredict_cnt), 32'(CMAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
